// File: rtl/cnn_mac_acc_round_sat.sv
// Purpose : accumulate one dot-product group of signed products plus a bias,
//           then round half-up, saturate to the 14-bit activation format and optionally ReLU.
// Latency : the result is registered; out_valid rises the cycle after the last beat of a group.
// Backpr. : prod_ready = ~out_valid | out_ready. Upstream stalls while a result is unconsumed.
//
// Ports
//   ap_clk, ap_rst          clock (rising edge); asynchronous active-high reset
//   prod_data/_valid/_last  signed product stream; _last marks the final term of a group
//   prod_ready              a beat is accepted when prod_valid & prod_ready
//   bias                    signed bias, sampled only on the first beat of a group
//   out_data/_valid/_ready  rounded, saturated result with a valid/ready handshake
//   err_overrun             sticky flag: a group ran past MAX_TERMS beats without last

module cnn_mac_acc_round_sat #(
  parameter int PROD_W    = 23,
  parameter int DATA_W    = 14,
  parameter int WGT_FRAC  = 8,
  parameter int ACC_W     = 33,
  parameter int MAX_TERMS = 512,
  parameter int RELU      = 0
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_valid,
  input  logic              prod_last,
  output logic              prod_ready,
  input  logic [DATA_W-1:0] bias,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_overrun
);

  localparam int CNT_W = $clog2(MAX_TERMS + 1);
  localparam logic [CNT_W-1:0] TERM_MAX = CNT_W'(MAX_TERMS);

  // Rounding constant 2^(WGT_FRAC-1), carried one bit wider than the
  // accumulator so the add cannot wrap even at the extreme positive sum.
  localparam logic [ACC_W:0] RND_HALF = {{ACC_W{1'b0}}, 1'b1} << (WGT_FRAC - 1);

  // Saturation bounds of the output format, in the widened result domain.
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  state_t                   state_q, state_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic                     out_vld_q, out_vld_d;
  logic [DATA_W-1:0]        out_dat_q, out_dat_d;

  // Handshake / datapath intermediates
  logic                     beat;
  logic                     first_beat;
  logic [ACC_W-1:0]         prod_ext;
  logic [ACC_W-1:0]         bias_ext;
  logic [ACC_W-1:0]         acc_base;
  logic [ACC_W-1:0]         sum;
  logic signed [ACC_W:0]    rnd_sum;
  logic signed [ACC_W:0]    shifted;
  logic [DATA_W-1:0]        sat_res;
  logic [DATA_W-1:0]        result;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (beat) begin
      // A last beat always closes the group, whether or not one was open.
      state_d = prod_last ? ST_IDLE : ST_ACC;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // A held result only blocks intake if downstream is not taking it now,
    // so a result slot is always free by the time a new last beat lands.
    prod_ready = ~out_vld_q | out_ready;
    beat       = prod_valid & prod_ready;
    first_beat = (state_q == ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Accumulate datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    prod_ext = {{(ACC_W - PROD_W){prod_data[PROD_W-1]}}, prod_data};
    // Bias has only the activation fraction; shift it up to the product scale.
    bias_ext = {{(ACC_W - DATA_W - WGT_FRAC){bias[DATA_W-1]}}, bias, {WGT_FRAC{1'b0}}};
    acc_base = first_beat ? bias_ext : acc_q;
    sum      = acc_base + prod_ext;
  end

  // ---------------------------------------------------------------------------
  // Round, saturate, optional ReLU
  // ---------------------------------------------------------------------------
  always_comb begin
    rnd_sum = {sum[ACC_W-1], sum} + RND_HALF;
    shifted = rnd_sum >>> WGT_FRAC;

    if (shifted > SAT_MAX) begin
      sat_res = {1'b0, {(DATA_W - 1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      sat_res = {1'b1, {(DATA_W - 1){1'b0}}};
    end else begin
      sat_res = shifted[DATA_W-1:0];
    end

    result = sat_res;
    if ((RELU != 0) && sat_res[DATA_W-1]) begin
      result = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state for accumulator, term counter, error flag and output register
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;

    // Consumed result drops out_valid unless a new one replaces it below.
    if (out_vld_q && out_ready) begin
      out_vld_d = 1'b0;
    end

    if (beat) begin
      if (prod_last) begin
        acc_d     = '0;
        cnt_d     = '0;
        out_vld_d = 1'b1;
        out_dat_d = result;
      end else begin
        acc_d = sum;
        if (first_beat) begin
          cnt_d = CNT_W'(1);
        end else if (cnt_q != TERM_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // The group is already full and still not closing: flag it, but keep
        // accumulating so the eventual result reflects every beat seen.
        if (cnt_q == TERM_MAX) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
    end
  end

  assign out_data    = out_dat_q;
  assign out_valid   = out_vld_q;
  assign err_overrun = err_q;

endmodule
